// File: rtl/mem_loader_pkg.sv
// Shared types and job defaults for the operand loader
// and the summing core it feeds.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_READ   = 3'd4,
    ST_RESULT = 3'd5
  } ld_state_e;

  localparam int NWORDS_DEF      = 10;
  localparam int RESULT_ADDR_DEF = 10;
  localparam int WAIT_CYCLES_DEF = 2;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;
  localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_loader.sv
// Streams NWORDS operands into data memory, kicks the summing
// core, then fetches and presents the result word.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int NWORDS      = NWORDS_DEF,
  parameter int RESULT_ADDR = RESULT_ADDR_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              startin,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready
);

  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(NWORDS - 1);
  localparam logic [ADDR_W-1:0] RES_ADDR =
    ADDR_W'(RESULT_ADDR);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(WAIT_CYCLES - 1);

  ld_state_e         r_state;
  ld_state_e         w_next;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fresh;
  logic [DATA_W-1:0] r_res;
  logic              w_accept;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    startin   = 1'b0;
    res_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept  = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = r_count;
          mem_wdata = in_data;
          if (r_count == LAST_IDX)
            w_next = ST_START;
        end
      end
      ST_START: begin
        startin = 1'b1;
        w_next  = (WAIT_CYCLES == 0) ?
                  ST_READ : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait == WAIT_LAST)
          w_next = ST_READ;
      end
      ST_READ: begin
        mem_re   = 1'b1;
        mem_addr = RES_ADDR;
        w_next   = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready)
          w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter saturates on the last word; IDLE rearms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_state == ST_IDLE) begin
      r_count <= '0;
    end else if (w_accept && r_count != LAST_IDX) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  // Read data lands in the first RESULT cycle; forward it
  // then and hold the captured copy afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fresh <= 1'b0;
      r_res   <= '0;
    end else begin
      r_fresh <= (r_state == ST_READ);
      if (r_fresh)
        r_res <= mem_rdata;
    end
  end

  assign res_data = r_fresh ? mem_rdata : r_res;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader with a behavioural
// data memory and summing core.
module tb_mem_loader;

  localparam int NW = 10;
  localparam int RA = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        startin;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [16];
  logic [31:0] words [NW];
  logic [35:0] exp_wr [$];
  logic [35:0] wr_obs [$];
  logic [31:0] exp_res [$];
  int n_start = 0;
  int n_clash = 0;

  int   jobcyc;
  int   ir_bad;
  int   we_bad;
  int   stable_bad;
  bit   timeout;
  logic [31:0] res_got;
  logic after_valid;
  logic after_ready;

  mem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .startin   (startin),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  function automatic logic [31:0] model_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < NW; i++) s += mem[i];
    return s;
  endfunction

  // Sync-read memory plus a summing core triggered by startin.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (startin) mem[RA] <= model_sum();
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) wr_obs.push_back({mem_addr, mem_wdata});
    if (startin) n_start++;
    if (mem_we && mem_re) n_clash++;
  end

  task automatic run_job(input bit gap, input int hold,
                         input bit offer_late);
    int idx = 0;
    int cyc = 0;
    int n   = 0;
    bit started = 0;
    logic [31:0] s = '0;
    logic [31:0] first;
    jobcyc = 0; ir_bad = 0; we_bad = 0;
    stable_bad = 0; timeout = 0;
    res_got = '0;
    res_ready = 1'b0;
    while (idx < NW && cyc < 200) begin
      @(posedge clk); #1;
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = words[idx];
      @(negedge clk);
      if (in_ready) started = 1;
      if (started) jobcyc++;
      if (in_valid && in_ready) begin
        exp_wr.push_back({4'(idx), words[idx]});
        s += words[idx];
        idx++;
      end
      cyc++;
    end
    if (idx < NW) timeout = 1;
    exp_res.push_back(s);
    @(posedge clk); #1;
    in_valid = offer_late;
    in_data  = 32'hDEAD_BEEF;
    while (n < 50) begin
      @(negedge clk);
      if (res_valid) break;
      if (in_ready) ir_bad++;
      if (mem_we) we_bad++;
      jobcyc++;
      n++;
      @(posedge clk); #1;
    end
    if (n >= 50) begin
      timeout = 1;
      return;
    end
    first = res_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!res_valid || res_data !== first || in_ready)
        stable_bad++;
    end
    res_ready = 1'b1;
    res_got = res_data;
    jobcyc++;
    @(posedge clk); #1;
    res_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    after_valid = res_valid;
    after_ready = in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_re, startin, res_valid}
        !== 5'b0 || mem_addr !== 4'd0 ||
        mem_wdata !== 32'd0 || res_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%h/%h/%h exp=0",
               {in_ready, mem_we, mem_re, startin, res_valid},
               mem_addr, mem_wdata, res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int st0 = n_start;
    logic [35:0] e, o;
    logic [31:0] r;
    for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
    run_job(0, 0, 0);
    n_checks++;
    if (timeout) begin
      n_fail++;
      $display("FAIL b2b_timeout got=1 exp=0");
    end
    n_checks++;
    if (wr_obs.size() != exp_wr.size()) begin
      n_fail++;
      $display("FAIL b2b_nwrites got=%0d exp=%0d",
               wr_obs.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && wr_obs.size() > 0) begin
      e = exp_wr.pop_front();
      o = wr_obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_write got=%h exp=%h", o, e);
      end
    end
    r = exp_res.pop_front();
    n_checks++;
    if (res_got !== r) begin
      n_fail++;
      $display("FAIL b2b_result got=%h exp=%h", res_got, r);
    end
    n_checks++;
    if (n_start - st0 != 1) begin
      n_fail++;
      $display("FAIL b2b_startin got=%0d exp=1", n_start - st0);
    end
    n_checks++;
    if (jobcyc != NW + 2 + 3) begin
      n_fail++;
      $display("FAIL b2b_length got=%0d exp=%0d",
               jobcyc, NW + 5);
    end
    n_checks++;
    if (after_valid !== 1'b0 || after_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got=%b%b exp=00",
               after_valid, after_ready);
    end
  endtask

  task automatic test_gaps();
    logic [35:0] e, o;
    logic [31:0] r;
    for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
    run_job(1, 0, 0);
    n_checks++;
    if (timeout || wr_obs.size() != NW) begin
      n_fail++;
      $display("FAIL gap_nwrites got=%0d exp=%0d",
               wr_obs.size(), NW);
    end
    while (exp_wr.size() > 0 && wr_obs.size() > 0) begin
      e = exp_wr.pop_front();
      o = wr_obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gap_write got=%h exp=%h", o, e);
      end
    end
    r = exp_res.pop_front();
    n_checks++;
    if (res_got !== r) begin
      n_fail++;
      $display("FAIL gap_result got=%h exp=%h", res_got, r);
    end
  endtask

  task automatic test_wrap_sum();
    logic [31:0] r;
    for (int i = 0; i < NW; i++) words[i] = 32'hFFFF_FFFF;
    run_job(0, 0, 0);
    exp_wr.delete();
    wr_obs.delete();
    r = exp_res.pop_front();
    n_checks++;
    if (timeout || res_got !== r) begin
      n_fail++;
      $display("FAIL wrap_result got=%h exp=%h", res_got, r);
    end
  endtask

  task automatic test_hold();
    logic [31:0] r;
    for (int i = 0; i < NW; i++) words[i] = 32'(3 * i + 7);
    run_job(0, 5, 0);
    exp_wr.delete();
    wr_obs.delete();
    r = exp_res.pop_front();
    n_checks++;
    if (timeout || res_got !== r) begin
      n_fail++;
      $display("FAIL hold_result got=%h exp=%h", res_got, r);
    end
    n_checks++;
    if (stable_bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable got=%0d exp=0", stable_bad);
    end
    n_checks++;
    if (after_valid !== 1'b0 || after_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle got=%b%b exp=00",
               after_valid, after_ready);
    end
  endtask

  task automatic test_late_offer();
    logic [31:0] r;
    for (int i = 0; i < NW; i++) words[i] = 32'(i * i);
    run_job(0, 0, 1);
    n_checks++;
    if (ir_bad != 0 || we_bad != 0) begin
      n_fail++;
      $display("FAIL late_offer got=%0d/%0d exp=0/0",
               ir_bad, we_bad);
    end
    n_checks++;
    if (wr_obs.size() != exp_wr.size()) begin
      n_fail++;
      $display("FAIL late_nwrites got=%0d exp=%0d",
               wr_obs.size(), exp_wr.size());
    end
    exp_wr.delete();
    wr_obs.delete();
    r = exp_res.pop_front();
    n_checks++;
    if (timeout || res_got !== r) begin
      n_fail++;
      $display("FAIL late_result got=%h exp=%h", res_got, r);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int cyc = 0;
    logic [35:0] e, o;
    logic [31:0] r;
    while (acc < 4 && cyc < 50) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 32'hA000_0000 + 32'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      cyc++;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_we, mem_re, startin, res_valid}
        !== 5'b0 || mem_addr !== 4'd0 ||
        mem_wdata !== 32'd0 || res_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%b/%h exp=0",
               {in_ready, mem_we, mem_re, startin, res_valid},
               mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_wr.delete();
    wr_obs.delete();
    for (int i = 0; i < NW; i++) words[i] = 32'(100 + i);
    run_job(0, 0, 0);
    n_checks++;
    if (timeout || wr_obs.size() != NW) begin
      n_fail++;
      $display("FAIL midreset_nwrites got=%0d exp=%0d",
               wr_obs.size(), NW);
    end
    while (exp_wr.size() > 0 && wr_obs.size() > 0) begin
      e = exp_wr.pop_front();
      o = wr_obs.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midreset_write got=%h exp=%h", o, e);
      end
    end
    r = exp_res.pop_front();
    n_checks++;
    if (res_got !== r) begin
      n_fail++;
      $display("FAIL midreset_result got=%h exp=%h",
               res_got, r);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_wrap_sum();
    test_hold();
    test_late_offer();
    test_reset_mid();
    n_checks++;
    if (n_clash != 0) begin
      n_fail++;
      $display("FAIL we_re_clash got=%0d exp=0", n_clash);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter NWORDS, default 10: number of operand words loaded per job.
REQ-002 Parameter RESULT_ADDR, default 10: memory word index holding the sum result.
REQ-003 Parameter WAIT_CYCLES, default 2: clocks from the startin pulse to the result read.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand word offered.
REQ-007 in_data  in  32  operand word.
REQ-008 in_ready  out  1  loader accepts the operand this cycle.
REQ-009 mem_we  out  1  data-memory write strobe.
REQ-010 mem_re  out  1  data-memory read strobe.
REQ-011 mem_addr  out  4  data-memory word index.
REQ-012 mem_wdata  out  32  data-memory write data.
REQ-013 mem_rdata  in  32  data-memory read data, valid 1 clock after mem_re.
REQ-014 startin  out  1  one-clock start pulse to the summing core.
REQ-015 res_valid  out  1  result word available.
REQ-016 res_data  out  32  captured result word.
REQ-017 res_ready  in  1  result consumer accepts res_data.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, START, WAIT, READ, RESULT.
- IDLE: word counter cleared; next state LOAD.
- LOAD: in_ready=1; on in_valid&&in_ready, mem_we=1, mem_addr=count, mem_wdata=in_data (same cycle, combinational), count++.
- LOAD exits to START when the accepted word is word NWORDS-1.
REQ-019 START SHALL assert startin for exactly one clock and then go to WAIT.
REQ-020 WAIT SHALL hold for WAIT_CYCLES clocks, then go to READ.
REQ-021 READ SHALL assert mem_re=1 with mem_addr=RESULT_ADDR for one clock; res_data SHALL capture mem_rdata on the following edge, after which the FSM goes to RESULT.
REQ-022 RESULT SHALL hold res_valid=1 with res_data stable until res_valid&&res_ready, then go to IDLE.
REQ-023 in_ready SHALL be 0 in every state except LOAD; words offered outside LOAD are not consumed.
REQ-024 mem_we and mem_re SHALL never be asserted in the same cycle; outside LOAD/READ both are 0 and mem_addr is 0.
REQ-025 The counter SHALL be 4 bits, count 0..NWORDS-1, and never wrap within a job.
REQ-026 Gaps in in_valid during LOAD SHALL stall the counter without a write.
REQ-027 res_ready asserted in the same cycle res_valid rises SHALL complete the transfer in that cycle; minimum IDLE-to-IDLE job length = NWORDS+WAIT_CYCLES+4 clocks.
REQ-028 res_data arithmetic is pass-through; the loader SHALL NOT modify the 32-bit result.

Reset
REQ-029 While rst_n=0 the FSM SHALL be in IDLE with count=0, res_data=0, and all outputs 0.
REQ-030 rst_n deassertion mid-job SHALL abandon the job; no partial-write recovery; the next job restarts at word 0.

Structure
REQ-031 State encoding and the default values of NWORDS, RESULT_ADDR, and WAIT_CYCLES SHALL live in a shared package used by the CPU core and this loader.
REQ-032 No sub-module is required; the FSM and counter are one module.

Verification
REQ-033 Load words 1..10 back-to-back; model memory sums into word 10 -> mem_we on 10 consecutive cycles at addresses 0..9, one startin pulse, res_data=55, res_valid=1.
REQ-034 Same words with in_valid deasserted every other cycle -> addresses still 0..9 in order, no extra writes, res_data=55.
REQ-035 Words 32'hFFFFFFFF x10 -> res_data=32'hFFFFFFF6 (mod-2^32 sum passed through unchanged).
REQ-036 Hold res_ready=0 for 5 clocks in RESULT -> res_valid and res_data stable; in_ready=0 throughout; IDLE entered the cycle after res_ready=1.
REQ-037 Pulse rst_n low after 4 words loaded -> all outputs 0 asynchronously; next job writes from address 0, result correct.
REQ-038 in_valid=1 during WAIT/READ -> in_ready=0, no mem_we.
